// File: rtl/port_fifo.sv
// port_fifo: show-ahead circular flit FIFO for one router input port.
// The head flit feeds the crossbar directly and req_o decodes its destination port.
module port_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic [4:0]                 req_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       ovf_o,
  output logic                       udf_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             full_s, empty_s;
  logic             push_ok_s, pop_ok_s;
  logic [WIDTH-1:0] head_s;
  logic [4:0]       req_s;

  assign full_s  = (count_q == CW'(DEPTH));
  assign empty_s = (count_q == CW'(0));

  // Accept/reject decisions and next-state for pointers, occupancy and sticky flags
  always_comb begin
    push_ok_s = push_i & ~full_s;
    pop_ok_s  = pop_i & ~empty_s;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q | (push_i & full_s);
    udf_d = udf_q | (pop_i & empty_s);
  end

  // Control state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Flit storage; contents are never visible while empty, so no reset
  always_ff @(posedge clk_i) begin
    if (rst_ni && push_ok_s) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Show-ahead head flit and destination decode (codes 5-7 fold onto local)
  always_comb begin
    head_s = '0;
    req_s  = 5'b00000;
    if (!empty_s) begin
      head_s = mem_q[rd_ptr_q];
      case (head_s[WIDTH-1 -: 3])
        3'd0:    req_s = 5'b00001;
        3'd1:    req_s = 5'b00010;
        3'd2:    req_s = 5'b00100;
        3'd3:    req_s = 5'b01000;
        default: req_s = 5'b10000;
      endcase
    end else begin
      head_s = '0;
      req_s  = 5'b00000;
    end
  end

  assign head_o  = head_s;
  assign req_o   = req_s;
  assign empty_o = empty_s;
  assign full_o  = full_s;
  assign count_o = count_q;
  assign ovf_o   = ovf_q;
  assign udf_o   = udf_q;

endmodule
